quad_gen: RTL and testbench

QUAD_GEN -- requirements
Module: quad_gen

---
 rtl/quad_gen.sv | 146 ++++++++++++++
 tb/tb_quad_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/quad_gen.sv
// Quadrature A/B edge generator: emits a commanded number of encoder edges at a
// programmable spacing, tracks net position, and supports abort.
module quad_gen #(
  parameter int unsigned MIN_PERIOD = 2
) (
  input  logic               clk_50,
  input  logic               reset_counts,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic signed [31:0] cmd_steps,
  input  logic        [31:0] cmd_period,
  input  logic               abort,
  output logic               a,
  output logic               b,
  output logic signed [31:0] position,
  output logic               direction,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic               live_q;
  logic               a_q, a_d, b_q, b_d;
  logic signed [31:0] pos_q, pos_d;
  logic               dir_q, dir_d;
  logic               abrt_q, abrt_d;
  logic        [31:0] per_q, per_d, cnt_q, cnt_d, rem_q, rem_d;

  logic               accept;
  logic               edge_now;
  logic        [31:0] per_eff;
  logic        [31:0] steps_mag;

  // Forward walks 00 -> 10 -> 11 -> 01 -> 00; reverse is the exact inverse.
  function automatic logic [1:0] step_phase(input logic [1:0] ab, input logic fwd);
    logic [1:0] nxt;
    nxt = ab;
    if (fwd) begin
      case (ab)
        2'b00:   nxt = 2'b10;
        2'b10:   nxt = 2'b11;
        2'b11:   nxt = 2'b01;
        default: nxt = 2'b00;
      endcase
    end else begin
      case (ab)
        2'b00:   nxt = 2'b01;
        2'b01:   nxt = 2'b11;
        2'b11:   nxt = 2'b10;
        default: nxt = 2'b00;
      endcase
    end
    return nxt;
  endfunction

  assign cmd_ready = live_q && (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign per_eff   = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
  assign steps_mag = cmd_steps[31] ? $unsigned(-cmd_steps) : $unsigned(cmd_steps);
  assign edge_now  = (state_q == RUN) && (cnt_q == 32'd1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    abrt_d  = abrt_q;
    per_d   = per_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          per_d  = per_eff;
          cnt_d  = per_eff;
          rem_d  = steps_mag;
          abrt_d = 1'b0;
          if (cmd_steps > 0)      dir_d = 1'b1;
          else if (cmd_steps < 0) dir_d = 1'b0;
          state_d = (cmd_steps == 0) ? DONE : RUN;
        end
      end
      RUN: begin
        // An abort landing on an edge cycle still lets that edge go out.
        if (edge_now) begin
          {a_d, b_d} = step_phase({a_q, b_q}, dir_q);
          pos_d      = pos_q + (dir_q ? 32'sd1 : -32'sd1);
          rem_d      = rem_q - 32'd1;
          cnt_d      = per_q;
          if ((rem_q == 32'd1) || abort) begin
            state_d = DONE;
            abrt_d  = abort;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
          if (abort) begin
            state_d = DONE;
            abrt_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset_counts) begin
    if (reset_counts) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pos_q   <= '0;
      dir_q   <= 1'b1;
      abrt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      a_q     <= a_d;
      b_q     <= b_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      abrt_q  <= abrt_d;
    end
  end

  // Timing counters are only meaningful in RUN, so they carry no reset.
  always_ff @(posedge clk_50) begin
    per_q <= per_d;
    cnt_q <= cnt_d;
    rem_q <= rem_d;
  end

  assign a         = a_q;
  assign b         = b_q;
  assign position  = pos_q;
  assign direction = dir_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign aborted   = (state_q == DONE) && abrt_q;

endmodule

// File: tb/tb_quad_gen.sv
// Scoreboard bench for quad_gen: a cycle-level move model queues expected edges
// and done pulses; a negedge monitor pops them as the DUT produces them.
module tb_quad_gen;

  logic               clk_50 = 1'b0;
  logic               reset_counts, cmd_valid, cmd_ready, abort;
  logic               a, b, direction, busy, done, aborted;
  logic signed [31:0] cmd_steps, position;
  logic        [31:0] cmd_period;

  always #5 clk_50 = ~clk_50;

  quad_gen #(.MIN_PERIOD(2)) dut (
    .clk_50(clk_50), .reset_counts(reset_counts),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .a(a), .b(b), .position(position), .direction(direction),
    .busy(busy), .done(done), .aborted(aborted)
  );

  typedef struct {
    bit                 is_done;
    longint             cyc;
    logic        [1:0]  ab;
    logic signed [31:0] pos;
    bit                 abt;
    bit                 dir;
  } ev_t;

  ev_t                sb[$];
  ev_t                mev;
  int                 n_tests = 0;
  int                 n_fail  = 0;
  longint             cyc     = 0;
  bit                 mon_en  = 1'b0;
  logic        [1:0]  prev_ab = 2'b00;

  // Reference state: phase index into the forward cycle, net position, direction.
  int                 m_phase = 0;
  logic signed [31:0] m_pos   = 0;
  bit                 m_dir   = 1'b1;
  logic        [1:0]  ph_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_50) begin
    if (!mon_en) begin
      prev_ab = {a, b};
    end else begin
      if ({a, b} != prev_ab) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_edge: got ab=%b at cycle %0d, expected no edge", {a, b}, cyc);
        end else begin
          mev = sb.pop_front();
          check("edge_kind", 0, longint'(mev.is_done));
          check("edge_cycle", cyc, mev.cyc);
          check("edge_ab", longint'({a, b}), longint'(mev.ab));
          check("edge_pos", longint'(position), longint'(mev.pos));
        end
        prev_ab = {a, b};
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
        end else begin
          mev = sb.pop_front();
          check("done_kind", 1, longint'(mev.is_done));
          check("done_cycle", cyc, mev.cyc);
          check("done_aborted", longint'(aborted), longint'(mev.abt));
          check("done_direction", longint'(direction), longint'(mev.dir));
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    @(negedge clk_50);
    n = 1;
    while ((sb.size() > 0 || !cmd_ready) && n < budget) begin
      @(negedge clk_50);
      n++;
    end
    if (n >= budget) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: got %0d pending events, expected 0 within %0d cycles", sb.size(), budget);
      sb.delete();
    end
  endtask

  // abort_at: cycles after acceptance at whose rising edge abort is sampled (0 = none).
  task automatic run_move(input longint steps, input longint period, input longint abort_at);
    longint p, n, e, donec, acc;
    bit     fwd, abt;
    ev_t    ev;
    wait_idle(400);
    cmd_valid  = 1'b1;
    cmd_steps  = steps[31:0];
    cmd_period = period[31:0];
    abort      = 1'($urandom_range(0, 1));
    acc        = cyc + 1;
    p     = (period < 2) ? 2 : period;
    n     = (steps < 0) ? -steps : steps;
    fwd   = (steps > 0);
    e     = n;
    donec = acc + n * p;
    abt   = 1'b0;
    if (abort_at > 0 && n > 0 && abort_at <= n * p) begin
      e     = abort_at / p;
      donec = acc + abort_at;
      abt   = 1'b1;
    end
    if (steps != 0) m_dir = fwd;
    for (longint k = 1; k <= e; k++) begin
      m_phase = fwd ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
      m_pos   = m_pos + (fwd ? 32'sd1 : -32'sd1);
      ev = '{is_done: 1'b0, cyc: acc + k * p, ab: ph_tab[m_phase], pos: m_pos, abt: 1'b0, dir: m_dir};
      sb.push_back(ev);
    end
    ev = '{is_done: 1'b1, cyc: donec, ab: ph_tab[m_phase], pos: m_pos, abt: abt, dir: m_dir};
    sb.push_back(ev);
    @(negedge clk_50);
    cmd_valid  = 1'b0;
    cmd_steps  = $urandom;
    cmd_period = $urandom;
    abort      = 1'b0;
    if (abort_at > 0) begin
      while (cyc < acc + abort_at - 1) @(negedge clk_50);
      abort = 1'b1;
      @(negedge clk_50);
      abort = 1'b0;
    end
  endtask

  initial begin
    reset_counts = 1'b1;
    cmd_valid    = 1'b0;
    abort        = 1'b0;
    cmd_steps    = '0;
    cmd_period   = '0;
    #12;
    check("rst_a", longint'(a), 0);
    check("rst_b", longint'(b), 0);
    check("rst_position", longint'(position), 0);
    check("rst_direction", longint'(direction), 1);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_cmd_ready", longint'(cmd_ready), 0);
    @(negedge clk_50);
    reset_counts = 1'b0;
    check("release_ready_low", longint'(cmd_ready), 0);
    @(negedge clk_50);
    check("release_ready_high", longint'(cmd_ready), 1);
    mon_en = 1'b1;

    run_move(5, 4, 0);
    run_move(-3, 10, 0);
    run_move(4, 0, 0);
    run_move(0, 7, 0);
    run_move(100, 3, 22);
    run_move(10, 5, 15);
    run_move(2, 3, 6);
    run_move(-64'sd2147483648, 2, 9);

    for (int i = 0; i < 25; i++) begin
      longint st, pr, ab;
      st = longint'($urandom_range(0, 12)) - 6;
      pr = longint'($urandom_range(0, 6));
      ab = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(1, 40)) : 0;
      run_move(st, pr, ab);
    end

    // Reset in the middle of a long move.
    run_move(50, 3, 0);
    repeat (10) @(negedge clk_50);
    mon_en = 1'b0;
    #2 reset_counts = 1'b1;
    #1;
    check("midrst_a", longint'(a), 0);
    check("midrst_b", longint'(b), 0);
    check("midrst_position", longint'(position), 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_ready", longint'(cmd_ready), 0);
    sb.delete();
    m_phase = 0;
    m_pos   = 0;
    m_dir   = 1'b1;
    repeat (2) @(negedge clk_50);
    reset_counts = 1'b0;
    check("midrst_release_ready_low", longint'(cmd_ready), 0);
    @(negedge clk_50);
    check("midrst_release_ready_high", longint'(cmd_ready), 1);
    mon_en = 1'b1;
    repeat (8) @(negedge clk_50);
    run_move(-2, 3, 0);
    run_move(3, 2, 0);

    wait_idle(400);
    check("scoreboard_empty", longint'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
